// File: rtl/infer_seq_ctrl_if.sv
// ============================================================================
// Module   : infer_seq_ctrl_if
// Purpose  : Host, CNN-core and threshold-stage signals of the inference sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface infer_seq_ctrl_if #(
  parameter int ACC_BITS = 26,
  parameter int CNT_BITS = 16
);
  logic                frame_req;
  logic                frame_ack;
  logic                cnn_start;
  logic                cnn_done;
  logic [ACC_BITS-1:0] cnn_sum;
  logic [ACC_BITS-1:0] cmp_sum;
  logic                cmp_valid;
  logic                res_valid;
  logic                res_is_one;
  logic                disp_hold;
  logic                busy;
  logic                timeout_err;
  logic [CNT_BITS-1:0] one_cnt;
  logic [CNT_BITS-1:0] zero_cnt;
  logic                clear;

  // Sequencer side
  modport master (
    input  frame_req, cnn_done, cnn_sum, res_valid, res_is_one, clear,
    output frame_ack, cnn_start, cmp_sum, cmp_valid, disp_hold, busy,
           timeout_err, one_cnt, zero_cnt
  );

  // Host / CNN core / threshold stage side
  modport slave (
    output frame_req, cnn_done, cnn_sum, res_valid, res_is_one, clear,
    input  frame_ack, cnn_start, cmp_sum, cmp_valid, disp_hold, busy,
           timeout_err, one_cnt, zero_cnt
  );
endinterface

`default_nettype wire

// File: rtl/infer_seq_ctrl.sv
// ============================================================================
// Module   : infer_seq_ctrl
// Purpose  : Single-frame CNN inference sequencer with watchdog, display hold
//            and saturating one/zero tallies.
// Revision : 1.0
// ============================================================================
`default_nettype none

module infer_seq_ctrl #(
  parameter int ACC_BITS    = 26,
  parameter int TIMEOUT     = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_BITS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  infer_seq_ctrl_if.master  bus
);

  localparam int c_TMAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int c_TW   = $clog2(c_TMAX + 1);
  localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_HOLD_LAST = c_TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam bit              c_HOLD_EN   = (HOLD_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_CMP    = 3'd3,
    S_RESULT = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_TW-1:0]      r_timer, w_timer_nxt;
  logic                 w_ack, w_capture, w_to_set, w_one_inc, w_zero_inc;

  logic                 r_frame_ack, r_cnn_start, r_cmp_valid, r_disp_hold, r_busy;
  logic                 r_timeout_err;
  logic [ACC_BITS-1:0]  r_cmp_sum;
  logic [CNT_BITS-1:0]  r_one_cnt, r_zero_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_ack       = 1'b0;
    w_capture   = 1'b0;
    w_to_set    = 1'b0;
    w_one_inc   = 1'b0;
    w_zero_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_req) begin
          w_ack       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // cnn_done takes priority over an expiring watchdog in the same cycle
        if (bus.cnn_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CMP;
        end else if (r_timer == c_TO_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_TW'(1);
        end
      end
      S_CMP: begin
        w_timer_nxt = '0;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (bus.res_valid) begin
          w_one_inc   = bus.res_is_one;
          w_zero_inc  = !bus.res_is_one;
          w_timer_nxt = '0;
          w_state_nxt = c_HOLD_EN ? S_HOLD : S_IDLE;
        end else if (r_timer == c_TO_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_TW'(1);
        end
      end
      S_HOLD: begin
        if (r_timer == c_HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so each is high exactly while in its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_ack   <= 1'b0;
      r_cnn_start   <= 1'b0;
      r_cmp_valid   <= 1'b0;
      r_disp_hold   <= 1'b0;
      r_busy        <= 1'b0;
      r_cmp_sum     <= '0;
      r_timeout_err <= 1'b0;
      r_one_cnt     <= '0;
      r_zero_cnt    <= '0;
    end else begin
      r_frame_ack <= w_ack;
      r_cnn_start <= (w_state_nxt == S_START);
      r_cmp_valid <= (w_state_nxt == S_CMP);
      r_disp_hold <= (w_state_nxt == S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_cmp_sum <= bus.cnn_sum;
      end
      if (bus.clear) begin
        r_timeout_err <= 1'b0;
        r_one_cnt     <= '0;
        r_zero_cnt    <= '0;
      end else begin
        if (w_to_set) begin
          r_timeout_err <= 1'b1;
        end
        if (w_one_inc && !(&r_one_cnt)) begin
          r_one_cnt <= r_one_cnt + CNT_BITS'(1);
        end
        if (w_zero_inc && !(&r_zero_cnt)) begin
          r_zero_cnt <= r_zero_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  assign bus.frame_ack   = r_frame_ack;
  assign bus.cnn_start   = r_cnn_start;
  assign bus.cmp_valid   = r_cmp_valid;
  assign bus.cmp_sum     = r_cmp_sum;
  assign bus.disp_hold   = r_disp_hold;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.one_cnt     = r_one_cnt;
  assign bus.zero_cnt    = r_zero_cnt;

endmodule

`default_nettype wire

// File: doc/infer_seq_ctrl.md
Name: infer_seq_ctrl

Overview:
Sequencer for single-frame CNN inference. On each accepted frame request it starts the CNN core and waits, under a watchdog, for the accumulated sum. It then issues the sum to the threshold/seven-seg stage and holds the displayed digit for a programmable time. It also keeps saturating tallies of "1" and "0" classifications and a sticky timeout flag for the host/status LEDs.

Parameters:
ACC_BITS, 26, width of CNN accumulator sum (signed)
TIMEOUT, 1000000, max cycles to wait for cnn_done after cnn_start (>=2)
HOLD_CYCLES, 50000000, cycles the result is held on display before the next frame is accepted (0 = no hold)
CNT_BITS, 16, width of the one/zero tally counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_req  in  1  request to classify a frame (level; sampled in IDLE only)
frame_ack  out  1  one-cycle pulse: request accepted
cnn_start  out  1  one-cycle start pulse to CNN core
cnn_done  in  1  CNN result valid (one-cycle pulse)
cnn_sum  in  ACC_BITS  signed CNN sum, valid with cnn_done
cmp_sum  out  ACC_BITS  registered sum to threshold stage
cmp_valid  out  1  one-cycle valid to threshold stage
res_valid  in  1  threshold stage valid_out
res_is_one  in  1  threshold stage is_one
disp_hold  out  1  high while result is being held on display
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky: a watchdog expired
one_cnt  out  CNT_BITS  saturating count of "1" results
zero_cnt  out  CNT_BITS  saturating count of "0" results
clear  in  1  synchronous clear of counters and timeout_err

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including cmp_sum, counters, timer and timeout_err.
- All outputs are registered. FSM states: IDLE, START, WAIT, CMP, RESULT, HOLD.
- IDLE: if frame_req=1, frame_ack=1 for that transition and next state is START. Otherwise stay in IDLE.
- START: cnn_start=1 for exactly one cycle; timer cleared; next state is WAIT.
- WAIT, on cnn_done=1: capture cnn_sum into cmp_sum; next state is CMP.
- WAIT, otherwise: timer increments. When timer reaches TIMEOUT-1 without cnn_done, set timeout_err and go to IDLE. No cmp_valid is issued and no counter changes.
- WAIT, simultaneous events: cnn_done in the same cycle the timer reaches TIMEOUT-1 means done wins; there is no error.
- CMP: cmp_valid=1 for exactly one cycle with cmp_sum stable; timer cleared; next state is RESULT.
- RESULT, on res_valid=1: if res_is_one, one_cnt+1, else zero_cnt+1. Each counter saturates at all-ones. Then:
  - HOLD_CYCLES=0: go to IDLE.
  - Otherwise: go to HOLD with the timer cleared.
- RESULT, otherwise: the same TIMEOUT watchdog applies. On expiry, set timeout_err and go to IDLE with no count.
- HOLD: disp_hold=1. The timer counts up, and after HOLD_CYCLES cycles in HOLD the next state is IDLE. frame_req is ignored during HOLD.
- Latency, frame_ack to cmp_valid: 1 (START) + WAIT cycles + 1 cycle. With the threshold stage at 1 cycle, res_valid arrives the cycle after cmp_valid.
- frame_req held high continuously: a new frame is accepted on the first IDLE cycle after HOLD, giving back-to-back operation.
- cnn_done outside WAIT and res_valid outside RESULT are ignored; state, cmp_sum and counters are unchanged.
- clear: zeroes one_cnt, zero_cnt and timeout_err without affecting the FSM. Clear wins over a same-cycle increment or timeout set.
- Timer width: clog2(max(TIMEOUT, HOLD_CYCLES)+1) bits, unsigned, shared between WAIT/RESULT/HOLD.
- rst_n asserted mid-operation: immediate return to IDLE with all outputs 0. A pending cnn_done arriving after reset release is ignored.

Test Plan:
- Use TIMEOUT=20 and HOLD_CYCLES=8 for all scenarios below.
- Nominal "1": frame_req pulse, cnn_done 5 cycles after cnn_start with cnn_sum=+100, res_valid=1/res_is_one=1 next cycle. Required: frame_ack and cnn_start each pulse once; cmp_valid 1 cycle with cmp_sum=100; one_cnt=1; disp_hold high exactly 8 cycles; busy low afterwards.
- Nominal "0": cnn_sum=-7, res_is_one=0 -> zero_cnt=1, one_cnt unchanged, cmp_sum=-7 (sign preserved).
- Timeout: no cnn_done after cnn_start -> after 20 WAIT cycles, timeout_err=1, state IDLE, no cmp_valid. A subsequent clear -> timeout_err=0.
- Boundary: cnn_done on the exact expiry cycle -> no timeout_err, normal CMP/RESULT flow.
- Back-to-back and saturation: frame_req held high, CNT_BITS=2, 5 "1" frames -> one_cnt sticks at 3. frame_ack occurs once per frame, and never during HOLD.
- Reset mid-WAIT: assert rst_n=0 asynchronously (between clock edges) -> outputs 0 immediately. A cnn_done arriving after release -> no cmp_valid, counters 0.
